// File: rtl/la_wb_initiator.sv
// la_wb_initiator
//   Wishbone classic master driven from logic-analyzer probes. Firmware sets
//   the req_* fields, then flips req_toggle. The toggle is synchronised into
//   the payload clock domain. Each level change starts one Wishbone cycle.
//   Completion status and read data are reported back through done_toggle and
//   the rsp_* outputs.
//
// Ports
//   clock, reset_n          payload clock; async active-low reset
//   req_toggle              async request strobe, one txn per level change
//   req_we/sel/adr/dat      request payload, stable around the toggle
//   tmo_limit               bus timeout in cycles, 0 disables the timeout
//   busy                    a Wishbone cycle is in flight
//   done_toggle             flips once per completed or aborted txn
//   rsp_dat/err/tmo         last read data, error flag, timeout flag
//   overrun                 sticky: a request arrived while busy and was dropped
//   txn_count               completed transactions, wraps
//   wb_*                    Wishbone classic master port
module la_wb_initiator #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int TMO_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req_toggle,
  input  logic                 req_we,
  input  logic [SEL_WIDTH-1:0] req_sel,
  input  logic [ADR_WIDTH-1:0] req_adr,
  input  logic [DAT_WIDTH-1:0] req_dat,
  input  logic [TMO_WIDTH-1:0] tmo_limit,
  output logic                 busy,
  output logic                 done_toggle,
  output logic [DAT_WIDTH-1:0] rsp_dat,
  output logic                 rsp_err,
  output logic                 rsp_tmo,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] txn_count,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [SEL_WIDTH-1:0] wb_sel_o,
  output logic [ADR_WIDTH-1:0] wb_adr_o,
  output logic [DAT_WIDTH-1:0] wb_dat_o,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic [DAT_WIDTH-1:0] wb_dat_i
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  // sync_q[0] is the metastability flop; an edge is seen between [1] and [2].
  logic [2:0]           sync_q;
  logic                 req_edge;
  logic [0:0]           state_q;
  logic [TMO_WIDTH-1:0] timer_q;
  logic                 cyc_q;
  logic                 tmo_hit;
  logic                 finish;

  assign req_edge = sync_q[1] ^ sync_q[2];

  // Timer counts stalled BUS cycles already elapsed, so the abort lands on the
  // edge that ends the tmo_limit-th cycle of cyc high.
  assign tmo_hit = (tmo_limit != '0) && (timer_q == tmo_limit - TMO_WIDTH'(1));
  assign finish  = (state_q == BUS) && (wb_ack_i || wb_err_i || tmo_hit);

  assign busy     = (state_q == BUS);
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], req_toggle};
  end

  // Requests arriving while a cycle is in flight (including on the
  // completion edge) are dropped and flagged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           overrun <= 1'b0;
    else if (req_edge && state_q == BUS)    overrun <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cyc_q    <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_edge) begin
            state_q  <= BUS;
            cyc_q    <= 1'b1;
            timer_q  <= '0;
            wb_we_o  <= req_we;
            wb_sel_o <= req_sel;
            wb_adr_o <= req_adr;
            wb_dat_o <= req_dat;
          end
        end
        default: begin
          if (finish) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TMO_WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Response side: ack beats err beats timeout on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      done_toggle <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_tmo     <= 1'b0;
      txn_count   <= '0;
    end else if (finish) begin
      done_toggle <= ~done_toggle;
      txn_count   <= txn_count + CNT_WIDTH'(1);
      if (wb_ack_i) begin
        if (!wb_we_o) rsp_dat <= wb_dat_i;
        rsp_err <= 1'b0;
        rsp_tmo <= 1'b0;
      end else if (wb_err_i) begin
        rsp_err <= 1'b1;
        rsp_tmo <= 1'b0;
      end else begin
        rsp_err <= 1'b1;
        rsp_tmo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_la_wb_initiator.sv
module tb_la_wb_initiator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_toggle, req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr, req_dat;
  logic [7:0]  tmo_limit;
  logic        busy, done_toggle, rsp_err, rsp_tmo, overrun;
  logic [31:0] rsp_dat;
  logic [15:0] txn_count;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_ack_i, wb_err_i;
  logic [31:0] wb_dat_i;

  la_wb_initiator dut (
    .clock(clock), .reset_n(reset_n), .req_toggle(req_toggle), .req_we(req_we),
    .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat), .tmo_limit(tmo_limit),
    .busy(busy), .done_toggle(done_toggle), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .rsp_tmo(rsp_tmo), .overrun(overrun), .txn_count(txn_count),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_dat_i(wb_dat_i)
  );

  always #5 clock = ~clock;

  // mode: 0 never respond, 1 ack, 2 err, 3 ack+err; dly = BUS cycle of response
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    int          mode, dly;
    logic [31:0] rdat;
    logic [7:0]  tmo;
    int          exp_hi;
    logic [31:0] exp_dat;
    logic        exp_err, exp_tmo;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic        err, tmo;
    logic [15:0] cnt;
  } sb_t;

  sb_t         sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt = '0;
  logic        prev_done = 1'b0;
  vec_t        vecs[8];
  vec_t        v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Completion monitor: every done_toggle flip pops one expectation.
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset_n) prev_done = 1'b0;
    else if (done_toggle !== prev_done) begin
      prev_done = done_toggle;
      if (sb_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("rsp_dat", rsp_dat, e.dat);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_tmo", {31'd0, rsp_tmo}, {31'd0, e.tmo});
        chk("txn_count", {16'd0, txn_count}, {16'd0, e.cnt});
      end
    end
  end

  task automatic wait_rise(output int rise);
    rise = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (wb_cyc_o) begin rise = k; break; end
    end
  endtask

  // Acts as the slave while cyc is high; returns how many cycles cyc stayed up.
  task automatic serve(input int mode, input int dly, input logic [31:0] rdat, output int hi);
    int bad;
    hi = 0; bad = 0;
    while (wb_cyc_o && hi < 400) begin
      hi++;
      if (wb_stb_o !== 1'b1 || wb_we_o !== req_we || wb_sel_o !== req_sel ||
          wb_adr_o !== req_adr || wb_dat_o !== req_dat) bad++;
      wb_ack_i = (hi == dly) && (mode == 1 || mode == 3);
      wb_err_i = (hi == dly) && (mode >= 2);
      wb_dat_i = rdat;
      @(negedge clock);
    end
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    chk("bus_fields", bad, 0);
  endtask

  task automatic issue(input vec_t t, input logic push);
    @(negedge clock);
    req_we = t.we; req_sel = t.sel; req_adr = t.adr; req_dat = t.dat; tmo_limit = t.tmo;
    @(negedge clock);
    if (push) begin
      exp_cnt++;
      sb_q.push_back('{dat: t.exp_dat, err: t.exp_err, tmo: t.exp_tmo, cnt: exp_cnt});
    end
    req_toggle = ~req_toggle;
  endtask

  task automatic run_vec(input vec_t t);
    int rise, hi;
    issue(t, 1'b1);
    wait_rise(rise);
    chk("cyc_rise_latency", rise, 3);
    serve(t.mode, t.dly, t.rdat, hi);
    chk("cyc_high_cycles", hi, t.exp_hi);
    repeat (2) @(negedge clock);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int rise, hi, bad;
    vecs[0] = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,          1, 2, 32'hDEAD_BEEF, 8'd0,  2, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'h3, 32'h0000_1004, 32'h1234_5678,  1, 1, 32'h5555_5555, 8'd0,  1, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'hF, 32'h0000_1008, 32'h0,          0, 0, 32'h0,         8'd5,  5, 32'hDEAD_BEEF, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 4'hF, 32'h0000_100C, 32'h0,          3, 1, 32'hA5A5_0001, 8'd0,  1, 32'hA5A5_0001, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'h1, 32'h0000_1010, 32'h0,          1, 3, 32'h0BAD_F00D, 8'd3,  3, 32'h0BAD_F00D, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 4'hF, 32'h0000_1014, 32'h0,          2, 2, 32'hFFFF_FFFF, 8'd0,  2, 32'h0BAD_F00D, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'hC, 32'h0000_1018, 32'h8765_4321,  0, 0, 32'h0,         8'd1,  1, 32'h0BAD_F00D, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 4'hF, 32'h0000_101C, 32'h0,          1, 4, 32'h1357_9BDF, 8'd10, 4, 32'h1357_9BDF, 1'b0, 1'b0};

    reset_n = 1'b0; req_toggle = 1'b0; req_we = 1'b0; req_sel = '0; req_adr = '0;
    req_dat = '0; tmo_limit = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    repeat (3) @(negedge clock);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done_toggle}, 32'd0);
    chk("rst_txn_count", {16'd0, txn_count}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("done_after_first", {31'd0, done_toggle}, 32'd1);
    end

    // tmo_limit = 0: the cycle must stay open indefinitely
    v = '{1'b0, 4'hF, 32'h0000_2000, 32'h0, 1, 1, 32'h0C0F_FEE0, 8'd0, 1, 32'h0C0F_FEE0, 1'b0, 1'b0};
    issue(v, 1'b1);
    wait_rise(rise);
    chk("notmo_rise", rise, 3);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (!wb_cyc_o || !busy) bad++;
      @(negedge clock);
    end
    chk("notmo_held_300", bad, 0);
    serve(1, 1, 32'h0C0F_FEE0, hi);
    chk("notmo_ack_cycles", hi, 1);
    repeat (2) @(negedge clock);

    // Overrun: a second toggle lands while the first request is on the bus
    chk("overrun_clear", {31'd0, overrun}, 32'd0);
    v = '{1'b0, 4'hF, 32'h0000_3000, 32'h0, 1, 6, 32'h0000_0042, 8'd0, 6, 32'h0000_0042, 1'b0, 1'b0};
    issue(v, 1'b1);
    repeat (2) @(negedge clock);
    req_toggle = ~req_toggle;
    wait_rise(rise);
    chk("ovr_cyc_seen", {31'd0, wb_cyc_o}, 32'd1);
    serve(1, 6, 32'h0000_0042, hi);
    chk("ovr_cycles", hi, 6);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (wb_cyc_o) bad++;
      @(negedge clock);
    end
    chk("ovr_no_second_cycle", bad, 0);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_txn_count", {16'd0, txn_count}, {16'd0, exp_cnt});

    // Reset while cyc is high: bus drops asynchronously, nothing reported
    v = '{1'b0, 4'hF, 32'h0000_4000, 32'h0, 0, 0, 32'h0, 8'd0, 0, 32'h0, 1'b0, 1'b0};
    issue(v, 1'b0);
    wait_rise(rise);
    repeat (2) @(negedge clock);
    chk("mid_cyc_high", {31'd0, wb_cyc_o}, 32'd1);
    #2;
    reset_n = 1'b0;
    req_toggle = 1'b0;
    #1;
    chk("mid_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("mid_rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_txn", {16'd0, txn_count}, 32'd0);
    chk("mid_rst_done", {31'd0, done_toggle}, 32'd0);
    chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    sb_q.delete();
    exp_cnt = '0;
    reset_n = 1'b1;

    v = '{1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_BABE, 1, 1, 32'h0, 8'd0, 1, 32'h0, 1'b0, 1'b0};
    run_vec(v);
    repeat (4) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/la_wb_initiator.md
Name: la_wb_initiator

Overview:
- Parametrised Wishbone master driven from logic-analyzer probes.
- Supersedes the direct LA-to-Wishbone wiring in the user-project wrapper.
- Host firmware sets the request fields on LA lines, then flips a toggle. The block synchronises the toggle, runs one classic Wishbone cycle on the payload bus and reports data, error/timeout status and completion back over LA.
- Sits in the user-project wrapper in the payload clock domain, ahead of fwpayload's wba port.

Parameters:
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width; must be a multiple of 8.
- SEL_WIDTH, DAT_WIDTH/8, byte-select width.
- TMO_WIDTH, 8, width of timeout limit and timer.
- CNT_WIDTH, 16, width of completed-transaction counter.

Ports:
- clock  in  1  payload clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_toggle  in  1  request strobe (LA, asynchronous); each level change requests one transaction.
- req_we  in  1  1 = write, 0 = read.
- req_sel  in  SEL_WIDTH  byte selects.
- req_adr  in  ADR_WIDTH  address.
- req_dat  in  DAT_WIDTH  write data.
- tmo_limit  in  TMO_WIDTH  timeout in cycles; 0 = no timeout.
- busy  out  1  transaction in progress.
- done_toggle  out  1  flips once per completed/aborted transaction.
- rsp_dat  out  DAT_WIDTH  last read data.
- rsp_err  out  1  last transaction ended by wb_err_i or timeout.
- rsp_tmo  out  1  last transaction ended by timeout.
- overrun  out  1  sticky; a request was dropped because busy.
- txn_count  out  CNT_WIDTH  completed transactions, wraps.
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle/strobe (always equal).
- wb_we_o  out  1  Wishbone write enable.
- wb_sel_o  out  SEL_WIDTH  Wishbone byte selects.
- wb_adr_o  out  ADR_WIDTH  Wishbone address.
- wb_dat_o  out  DAT_WIDTH  Wishbone write data.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_dat_i  in  DAT_WIDTH  Wishbone read data.

Behaviour:
- Reset (async, reset_n=0) drives every output and register to 0, including the sync chain, state IDLE, timer and txn_count. wb_cyc_o/wb_stb_o fall immediately, mid-transaction included; no completion is reported.
- Synchroniser: req_toggle passes through flops s1->s2->s3. A request edge is s2 != s3.
- Request payload timing: req_* fields must be stable from at least 1 cycle before the toggle until busy rises. They are captured into the wb_* output registers on the edge that leaves IDLE.
- States: IDLE, BUS.
- IDLE + edge -> BUS. cyc/stb/we/sel/adr/dat are registered, so wb_cyc_o goes high after the 3rd rising edge following the toggle change. busy = (state==BUS). Timer cleared.
- BUS, wb_ack_i=1:
  - wb_cyc_o/wb_stb_o low after this edge; state -> IDLE.
  - If !wb_we_o, rsp_dat <= wb_dat_i; writes leave rsp_dat unchanged.
  - rsp_err <= 0, rsp_tmo <= 0; done_toggle flips; txn_count++.
- BUS, wb_err_i=1 (ack=0): same as ack, except rsp_dat unchanged and rsp_err <= 1.
- BUS, neither: timer++ (saturating).
  - If tmo_limit != 0 and timer == tmo_limit-1 on this edge, abort: cyc/stb low, rsp_err <= 1, rsp_tmo <= 1, done_toggle flips, txn_count++.
  - wb_cyc_o is therefore high for exactly tmo_limit cycles on a timeout.
- Priority on the same edge: ack > err > timeout.
- Edge detected while in BUS, including the completion edge: request dropped, overrun <= 1. overrun is cleared only by reset.
- wb_we_o/sel/adr/dat hold their last values in IDLE; only cyc/stb gate the bus.
- txn_count wraps from all-ones to 0.
- No combinational path from any input to any output.

Test Plan:
- Read with ack on 2nd BUS cycle:
  - Stimulus: reset, adr=0x0000_1000, we=0, sel=0xF, flip toggle, slave returns 0xDEADBEEF.
  - Required: wb_cyc_o rises after edge 3, high exactly 2 cycles; rsp_dat=0xDEADBEEF, rsp_err=0, done_toggle=1, txn_count=1, busy low afterwards.
- Write:
  - Stimulus: we=1, dat=0x12345678, sel=0x3, immediate ack.
  - Required: wb_dat_o=0x12345678 and wb_sel_o=0x3 while cyc high; rsp_dat unchanged; done_toggle flips.
- Timeout:
  - Stimulus: tmo_limit=5, slave never responds.
  - Required: cyc high exactly 5 cycles; rsp_err=1, rsp_tmo=1, txn_count++.
  - Repeat with tmo_limit=0 for 300 cycles: cyc stays high, busy=1.
- Priority: ack and err both high on the same edge -> rsp_err=0; ack arriving on the timeout edge -> rsp_tmo=0.
- Overrun: flip toggle twice 2 cycles apart while the slave stalls -> exactly one bus cycle, overrun=1, txn_count +1 only.
- Reset mid-transaction: assert reset_n=0 while cyc high -> wb_cyc_o low before the next clock edge; txn_count=0, done_toggle=0. A subsequent request completes normally.
